// File: rtl/ge_stage_chain.sv
// ge_stage_chain: sequential GE pass/bonus evaluator, one stage per clock, LFSR-driven random words.
// Define GE_RETRY_EN to give each run one retry of its first failing stage (adds retry_used port).
module ge_stage_chain #(
  parameter int NUM_STAGES = 3,
  parameter int EFF_W      = 7,
  parameter int HARD_W     = 5,
  parameter int PASS_TH    = 70,
  parameter int LIVER_TH   = 80,
  parameter int HARD_HI    = 16,
  parameter int HARD_LO    = 4,
  parameter int BON_T1     = 80,
  parameter int BON_T2     = 87,
  parameter int BON_T3     = 94
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [EFF_W-1:0]             effort,
  input  logic [NUM_STAGES*HARD_W-1:0] hard_vec,
  input  logic [7:0]                   seed,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [1:0]                   bonus,
  output logic [$clog2(NUM_STAGES):0]  fail_stage
`ifdef GE_RETRY_EN
  ,
  output logic                         retry_used
`endif
);

  localparam int IDX_W = $clog2(NUM_STAGES) + 1;
  localparam int SC_W  = EFF_W + 2;

  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [IDX_W-1:0]       ALL_PASS = IDX_W'(NUM_STAGES);
  localparam logic [HARD_W-1:0]      HARD_HI_U = HARD_W'(HARD_HI);
  localparam logic [HARD_W-1:0]      HARD_LO_U = HARD_W'(HARD_LO);
  localparam logic signed [SC_W-1:0] PASS_S  = SC_W'(PASS_TH);
  localparam logic signed [SC_W-1:0] LIVER_S = SC_W'(LIVER_TH);
  localparam logic signed [SC_W-1:0] BT1_S   = SC_W'(BON_T1);
  localparam logic signed [SC_W-1:0] BT2_S   = SC_W'(BON_T2);
  localparam logic signed [SC_W-1:0] BT3_S   = SC_W'(BON_T3);

  // S_IDLE: waiting for start | S_EVAL: one stage per cycle | S_DONE: publish results
  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

  state_t                      state, state_n;
  logic [EFF_W-1:0]            eff_q;
  logic [NUM_STAGES*HARD_W-1:0] hard_q;
  logic [7:0]                  lfsr;
  logic [IDX_W-1:0]            idx;
  logic [1:0]                  bonus_prev;
  logic                        pass_prev;
  logic                        fail_q;

  logic [HARD_W-1:0]           hard_cur;
  logic [2:0]                  add;
  logic signed [SC_W-1:0]      score_raw, score, liver_lhs;
  logic                        pass_test, pass_liver, stage_pass, last;
  logic [1:0]                  stage_bonus;
  logic                        fb;
  logic                        retry_avail;

  always_comb begin
    hard_cur = hard_q[idx*HARD_W +: HARD_W];
    fb       = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    last     = (idx == LAST_IDX);

    if (hard_cur >= HARD_HI_U)
      add = (lfsr[1:0] != 2'b00) ? 3'd7 : 3'd0;
    else if (hard_cur < HARD_LO_U)
      add = 3'd0;
    else
      add = {lfsr[3], 1'b0, lfsr[4]};

    // Full-width signed arithmetic: underflow clamps to zero instead of wrapping.
    score_raw = $signed({2'b00, eff_q}) - $signed(SC_W'(hard_cur)) + $signed(SC_W'(add));
    score     = score_raw[SC_W-1] ? '0 : score_raw;
    pass_test = (score >= PASS_S);

    liver_lhs  = $signed({2'b00, eff_q}) - $signed(SC_W'({bonus_prev, 2'b00}));
    pass_liver = (liver_lhs > LIVER_S) ? (lfsr[4] | lfsr[5]) : 1'b1;
    stage_pass = pass_test & pass_liver & pass_prev;

    if (score > BT3_S)      stage_bonus = 2'd3;
    else if (score > BT2_S) stage_bonus = 2'd2;
    else if (score > BT1_S) stage_bonus = 2'd1;
    else                    stage_bonus = 2'd0;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = S_EVAL;
      S_EVAL: begin
        if (!stage_pass) state_n = retry_avail ? S_EVAL : S_DONE;
        else if (last)   state_n = S_DONE;
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state == S_EVAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eff_q      <= '0;
      hard_q     <= '0;
      lfsr       <= 8'hA5;
      idx        <= '0;
      bonus_prev <= 2'd0;
      pass_prev  <= 1'b0;
      fail_q     <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      bonus      <= 2'd0;
      fail_stage <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            eff_q      <= effort;
            hard_q     <= hard_vec;
            lfsr       <= (seed == 8'h00) ? 8'hA5 : seed;
            idx        <= '0;
            bonus_prev <= 2'd0;
            pass_prev  <= 1'b1;
            fail_q     <= 1'b0;
          end
        end
        S_EVAL: begin
          lfsr <= {lfsr[6:0], fb};
          // A retried stage keeps idx and bonus_prev so it re-runs with only a new random word.
          if (stage_pass || !retry_avail) begin
            bonus_prev <= stage_bonus;
            pass_prev  <= stage_pass;
            fail_q     <= !stage_pass;
            if (stage_pass && !last) idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          done       <= 1'b1;
          pass       <= !fail_q;
          bonus      <= bonus_prev;
          fail_stage <= fail_q ? idx : ALL_PASS;
        end
        default: ;
      endcase
    end
  end

`ifdef GE_RETRY_EN
  logic retry_tok, retry_taken;

  assign retry_avail = retry_tok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_tok   <= 1'b0;
      retry_taken <= 1'b0;
      retry_used  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          retry_tok   <= 1'b1;
          retry_taken <= 1'b0;
        end
        S_EVAL: if (!stage_pass && retry_tok) begin
          retry_tok   <= 1'b0;
          retry_taken <= 1'b1;
        end
        S_DONE: retry_used <= retry_taken;
        default: ;
      endcase
    end
  end
`else
  assign retry_avail = 1'b0;
`endif

endmodule

// File: tb/tb_ge_stage_chain.sv
// Scoreboard bench for ge_stage_chain: runs push hand-computed results, a done monitor pops and compares.
// Expected values for both builds (with and without GE_RETRY_EN) are listed per vector.
module tb_ge_stage_chain;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [6:0]  effort;
  logic [14:0] hard_vec;
  logic [7:0]  seed;
  logic        busy, done, pass;
  logic [1:0]  bonus;
  logic [2:0]  fail_stage;
`ifdef GE_RETRY_EN
  logic        retry_used;
`endif

  ge_stage_chain dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .effort     (effort),
    .hard_vec   (hard_vec),
    .seed       (seed),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .bonus      (bonus),
    .fail_stage (fail_stage)
`ifdef GE_RETRY_EN
    ,
    .retry_used (retry_used)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int p; int b; int fs; int lat; int ru; } exp_t;
  typedef struct { string nm; exp_t x; int t0; } ent_t;

  ent_t q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  logic done_d   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp_v);
    chk_cnt++;
    if (act == exp_v) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
  endtask

  function automatic logic [14:0] hv(input logic [4:0] h0, input logic [4:0] h1, input logic [4:0] h2);
    return {h2, h1, h0};
  endfunction

  // Monitor: every done pulse must match the oldest pending run.
  always @(negedge clk) begin
    ent_t en;
    if (!rst && done) begin
      done_cnt++;
      check("done_pending", q.size(), 1);
      check("done_width", int'(done_d), 0);
      if (q.size() > 0) begin
        en = q.pop_front();
        check({en.nm, "_pass"}, int'(pass), en.x.p);
        check({en.nm, "_bonus"}, int'(bonus), en.x.b);
        check({en.nm, "_fail_stage"}, int'(fail_stage), en.x.fs);
        check({en.nm, "_latency"}, cyc - en.t0, en.x.lat);
`ifdef GE_RETRY_EN
        check({en.nm, "_retry_used"}, int'(retry_used), en.x.ru);
`endif
      end
    end
    done_d = done;
  end

  function automatic ent_t mk(input string nm, input exp_t xn, input exp_t xr, input int t0);
    ent_t en;
    en.nm = nm;
`ifdef GE_RETRY_EN
    en.x = xr;
`else
    en.x = xn;
`endif
    en.t0 = t0;
    return en;
  endfunction

  task automatic run(input string nm, input logic [6:0] e, input logic [14:0] h,
                     input logic [7:0] s, input exp_t xn, input exp_t xr);
    int dc0;
    int w;
    @(negedge clk);
    effort = e; hard_vec = h; seed = s; start = 1'b1;
    q.push_back(mk(nm, xn, xr, cyc + 1));
    dc0 = done_cnt;
    @(negedge clk);
    start = 1'b0;
    check({nm, "_busy"}, int'(busy), 1);
    w = 0;
    while (done_cnt == dc0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check({nm, "_done_seen"}, done_cnt - dc0, 1);
    if (done_cnt == dc0 && q.size() > 0) void'(q.pop_back());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc0;
    rst = 1'b1; start = 1'b0; effort = '0; hard_vec = '0; seed = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_bonus", int'(bonus), 0);
    check("rst_fail_stage", int'(fail_stage), 0);
`ifdef GE_RETRY_EN
    check("rst_retry_used", int'(retry_used), 0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // All pass with liver inactive; start held high through EVAL and DONE must be ignored.
    @(negedge clk);
    effort = 7'd80; hard_vec = hv(5'd2, 5'd2, 5'd2); seed = 8'h01; start = 1'b1;
    q.push_back(mk("v1_allpass", exp_t'{1, 0, 3, 4, 0}, exp_t'{1, 0, 3, 4, 0}, cyc + 1));
    dc0 = done_cnt;
    @(negedge clk);
    effort = 7'd0; hard_vec = hv(5'd31, 5'd31, 5'd31); seed = 8'h00;
    repeat (4) @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("ignored_start_one_done", done_cnt - dc0, 1);

    run("v2_score69", 7'd69, hv(5'd0, 5'd0, 5'd0), 8'h01,
        exp_t'{0, 0, 0, 2, 0}, exp_t'{0, 0, 0, 3, 1});
    run("v3a_vhard_add0", 7'd90, hv(5'd20, 5'd2, 5'd2), 8'h30,
        exp_t'{0, 2, 2, 4, 0}, exp_t'{0, 2, 2, 5, 1});
    run("v3b_vhard_add7", 7'd90, hv(5'd20, 5'd31, 5'd2), 8'h31,
        exp_t'{0, 0, 1, 3, 0}, exp_t'{0, 0, 1, 4, 1});
    run("v4_clamp", 7'd5, hv(5'd31, 5'd31, 5'd31), 8'h55,
        exp_t'{0, 0, 0, 2, 0}, exp_t'{0, 0, 0, 3, 1});
    run("v5_seed0_retry", 7'd90, hv(5'd20, 5'd20, 5'd20), 8'h00,
        exp_t'{0, 0, 1, 3, 0}, exp_t'{1, 0, 3, 5, 1});
    run("v6_medium", 7'd75, hv(5'd8, 5'd8, 5'd8), 8'h18,
        exp_t'{0, 0, 1, 3, 0}, exp_t'{0, 0, 1, 4, 1});
    run("v7_bonus3", 7'd127, hv(5'd0, 5'd0, 5'd0), 8'h18,
        exp_t'{1, 3, 3, 4, 0}, exp_t'{1, 3, 3, 4, 0});

    // Reset in the middle of a run: outputs clear at once and no done follows.
    @(negedge clk);
    effort = 7'd127; hard_vec = hv(5'd0, 5'd0, 5'd0); seed = 8'h18; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dc0 = done_cnt;
    rst = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_pass", int'(pass), 0);
    check("midrst_bonus", int'(bonus), 0);
    check("midrst_fail_stage", int'(fail_stage), 0);
    check("midrst_done", int'(done), 0);
`ifdef GE_RETRY_EN
    check("midrst_retry_used", int'(retry_used), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("midrst_no_done", done_cnt - dc0, 0);
    check("midrst_idle", int'(busy), 0);

    run("v8_bonus_prev_liver", 7'd84, hv(5'd0, 5'd0, 5'd0), 8'hA5,
        exp_t'{1, 1, 3, 4, 0}, exp_t'{1, 1, 3, 4, 0});

    repeat (4) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
